// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit.
// Next-PC select encoding is also consumed by trace/debug logic.
package pc_pkg;

  localparam int XLEN_DEF = 16;

  typedef enum logic [2:0] {
    SEL_TRAP,
    SEL_REDIR,
    SEL_RET,
    SEL_UNDER,
    SEL_HOLD,
    SEL_INC
  } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack for call/return prediction.
// A push when full overwrites the oldest entry.
module pc_ras
  import pc_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic [XLEN-1:0] push_data,
  input  logic            pop,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] DEPTH = (PW+1)'(RAS_DEPTH);

  logic [XLEN-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_up;
  logic [PW:0]     count;

  assign ptr_up = ptr + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr_up;
      if (count != DEPTH)
        count <= count + 1'b1;
    end else if (pop && count != '0) begin
      ptr   <= ptr - 1'b1;
      count <= count - 1'b1;
    end
  end

  // Storage needs no reset; count gates what is visible.
  always_ff @(posedge clk) begin
    if (push && !reset)
      mem[ptr_up] <= push_data;
  end

  assign top   = mem[ptr];
  assign empty = (count == '0);
  assign full  = (count == DEPTH);

endmodule

// File: rtl/pc_unit.sv
// Program counter with stall, trap entry, epc capture and RAS.
// Sits at the head of fetch and drives the imem address.
module pc_unit
  import pc_pkg::*;
#(
  parameter int            XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(16'h0010),
  parameter int            INC       = 1,
  parameter int            RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            call,
  input  logic            ret,
  input  logic            trap,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next,
  output logic [XLEN-1:0] epc,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_underflow
);

  localparam logic [XLEN-1:0] INC_V = XLEN'(INC);

  pc_sel_e         sel;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] ras_top;
  logic            push;
  logic            pop;

  assign pc_inc = pc + INC_V;

  always_comb begin
    sel = SEL_INC;
    if (trap)
      sel = SEL_TRAP;
    else if (redirect)
      sel = SEL_REDIR;
    else if (ret && !ras_empty)
      sel = SEL_RET;
    else if (ret)
      sel = SEL_UNDER;
    else if (stall)
      sel = SEL_HOLD;
  end

  always_comb begin
    pc_next = pc_inc;
    unique case (sel)
      SEL_TRAP:  pc_next = TRAP_VEC;
      SEL_REDIR: pc_next = redirect_target;
      SEL_RET:   pc_next = ras_top;
      SEL_UNDER: pc_next = TRAP_VEC;
      SEL_HOLD:  pc_next = pc;
      SEL_INC:   pc_next = pc_inc;
      default:   pc_next = pc_inc;
    endcase
  end

  // A call only counts when the redirect actually wins.
  assign push = (sel == SEL_REDIR) && call;
  assign pop  = (sel == SEL_RET);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc            <= RESET_VEC;
      epc           <= '0;
      ras_underflow <= 1'b0;
    end else begin
      pc            <= pc_next;
      ras_underflow <= (sel == SEL_UNDER);
      if (sel == SEL_TRAP || sel == SEL_UNDER)
        epc <= pc;
    end
  end

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (pc_inc),
    .pop       (pop),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed vector table, hand sequences,
// and random traffic against a queue-based reference model.
module tb_pc_unit;

  localparam logic [15:0] TV = 16'h0010;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, redirect, call, ret, trap;
  logic [15:0] redirect_target;
  logic [15:0] pc, pc_next, epc;
  logic        ras_empty, ras_full, ras_underflow;

  logic       z4;
  logic [3:0] tgt4;
  logic [3:0] pc4, pc_next4, epc4;
  logic       e4, f4, u4;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_pc, m_epc;
  logic        m_under;
  logic [15:0] q[$];

  always #5 clk = ~clk;

  pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect(redirect), .redirect_target(redirect_target),
    .call(call), .ret(ret), .trap(trap),
    .pc(pc), .pc_next(pc_next), .epc(epc),
    .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_underflow(ras_underflow)
  );

  pc_unit #(.XLEN(4), .TRAP_VEC(4'h3)) dut4 (
    .clk(clk), .reset(reset), .stall(z4),
    .redirect(z4), .redirect_target(tgt4),
    .call(z4), .ret(z4), .trap(z4),
    .pc(pc4), .pc_next(pc_next4), .epc(epc4),
    .ras_empty(e4), .ras_full(f4), .ras_underflow(u4)
  );

  typedef struct {
    logic        st, rd, cl, rt, tr;
    logic [15:0] tgt;
    logic [15:0] exp_pc;
  } vec_t;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0;
    m_epc = 16'h0;
    m_under = 1'b0;
    q.delete();
  endtask

  function automatic logic [15:0] model_next();
    if (trap) return TV;
    if (redirect) return redirect_target;
    if (ret && q.size() > 0) return q[$];
    if (ret) return TV;
    if (stall) return m_pc;
    return m_pc + 16'd1;
  endfunction

  task automatic model_commit(input logic [15:0] npc);
    m_under = 1'b0;
    if (trap) m_epc = m_pc;
    else if (redirect) begin
      if (call) begin
        q.push_back(m_pc + 16'd1);
        if (q.size() > 4) void'(q.pop_front());
      end
    end else if (ret) begin
      if (q.size() > 0) void'(q.pop_back());
      else begin
        m_epc = m_pc;
        m_under = 1'b1;
      end
    end
    m_pc = npc;
  endtask

  task automatic apply(input logic st, rd, cl, rt, tr,
                       input logic [15:0] tgt);
    logic [15:0] npc;
    stall = st; redirect = rd; call = cl;
    ret = rt; trap = tr; redirect_target = tgt;
    #1;
    npc = model_next();
    check("pc_next", pc_next, npc);
    @(posedge clk);
    #1;
    model_commit(npc);
    check("pc", pc, m_pc);
    check("epc", epc, m_epc);
    check("empty", ras_empty, q.size() == 0);
    check("full", ras_full, q.size() == 4);
    check("underflow", ras_underflow, m_under);
  endtask

  vec_t tbl[$];

  function automatic vec_t mk(logic st, rd, cl, rt, tr,
                              logic [15:0] tgt, logic [15:0] e);
    vec_t v;
    v.st = st; v.rd = rd; v.cl = cl; v.rt = rt; v.tr = tr;
    v.tgt = tgt; v.exp_pc = e;
    return v;
  endfunction

  initial begin
    // stall, then stall+redirect, then free
    tbl.push_back(mk(0,1,0,0,0,16'h0005,16'h0005));
    tbl.push_back(mk(1,0,0,0,0,16'h0000,16'h0005));
    tbl.push_back(mk(1,1,0,0,0,16'h0040,16'h0040));
    tbl.push_back(mk(0,0,0,0,0,16'h0000,16'h0041));
    // call/return round trip
    tbl.push_back(mk(0,1,0,0,0,16'h0008,16'h0008));
    tbl.push_back(mk(0,1,1,0,0,16'h0100,16'h0100));
    tbl.push_back(mk(0,0,0,0,0,16'h0000,16'h0101));
    tbl.push_back(mk(0,0,0,0,0,16'h0000,16'h0102));
    tbl.push_back(mk(0,0,0,1,0,16'h0000,16'h0009));
    // five calls into a four-deep stack, five rets
    tbl.push_back(mk(0,1,0,0,0,16'd10,16'd10));
    tbl.push_back(mk(0,1,1,0,0,16'd20,16'd20));
    tbl.push_back(mk(0,1,1,0,0,16'd30,16'd30));
    tbl.push_back(mk(0,1,1,0,0,16'd40,16'd40));
    tbl.push_back(mk(0,1,1,0,0,16'd50,16'd50));
    tbl.push_back(mk(0,1,1,0,0,16'h0300,16'h0300));
    tbl.push_back(mk(0,0,0,1,0,16'h0000,16'd51));
    tbl.push_back(mk(1,0,0,1,0,16'h0000,16'd41));
    tbl.push_back(mk(0,0,0,1,0,16'h0000,16'd31));
    tbl.push_back(mk(0,0,0,1,0,16'h0000,16'd21));
    tbl.push_back(mk(0,0,0,1,0,16'h0000,TV));
    tbl.push_back(mk(0,0,0,0,0,16'h0000,16'h0011));
    // everything at once at pc=0x33
    tbl.push_back(mk(0,1,1,0,0,16'h0033,16'h0033));
    tbl.push_back(mk(1,1,1,1,1,16'h0099,TV));
    tbl.push_back(mk(0,0,0,1,0,16'h0000,16'h0012));
    // wrap
    tbl.push_back(mk(0,1,0,0,0,16'hFFFF,16'hFFFF));
    tbl.push_back(mk(0,0,0,0,0,16'h0000,16'h0000));
  end

  initial begin
    z4 = 1'b0; tgt4 = 4'h0;
    stall = 0; redirect = 0; call = 0; ret = 0; trap = 0;
    redirect_target = 16'h0;
    reset = 1'b1;
    #23;
    check("reset_pc", pc, 16'h0000);
    check("reset_epc", epc, 16'h0000);
    check("reset_empty", ras_empty, 1'b1);
    check("reset_full", ras_full, 1'b0);
    check("reset_uf", ras_underflow, 1'b0);
    reset = 1'b0;
    model_reset();

    for (int i = 1; i <= 16; i++) begin
      apply(0, 0, 0, 0, 0, 16'h0);
      check("free_pc", pc, 32'(i));
      check("wrap4_pc", pc4, 32'(i % 16));
    end

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].st, tbl[i].rd, tbl[i].cl,
            tbl[i].rt, tbl[i].tr, tbl[i].tgt);
      check($sformatf("vec%0d_pc", i), pc, tbl[i].exp_pc);
      if (tbl[i].exp_pc == TV && !tbl[i].tr)
        check("uf_epc", epc, 16'd21);
    end

    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(3) == 0,
            $urandom_range(3) == 0,
            $urandom_range(1) == 0,
            $urandom_range(4) == 0,
            $urandom_range(15) == 0,
            16'($urandom));
    end

    // async reset in the middle of a cycle after two pushes
    apply(0, 1, 1, 0, 0, 16'h0200);
    apply(0, 1, 1, 0, 0, 16'h0300);
    #3;
    reset = 1'b1;
    #1;
    check("async_pc", pc, 16'h0000);
    check("async_empty", ras_empty, 1'b1);
    check("async_epc", epc, 16'h0000);
    #2;
    reset = 1'b0;
    model_reset();
    apply(0, 0, 0, 1, 0, 16'h0);
    check("post_rst_uf", ras_underflow, 1'b1);
    check("post_rst_pc", pc, TV);
    apply(0, 0, 0, 0, 0, 16'h0);
    check("uf_pulse_end", ras_underflow, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit, next generation of the 16-bit PC register. It adds a configurable width, reset vector and increment, a stall input, trap entry with exception-PC capture, and a small circular return-address stack (RAS) for call/return. It sits at the head of the fetch stage and drives the instruction-memory address every cycle.

## Interface

Parameters:
- XLEN, 16, PC and address width in bits
- RESET_VEC, 0, PC value loaded on reset
- TRAP_VEC, 16'h0010, PC value loaded on trap or RAS underflow
- INC, 1, sequential step; word-addressed, 1 ≤ INC < 2^XLEN
- RAS_DEPTH, 4, return-address stack entries; power of two, ≥ 2

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- stall  in  1  hold PC; suppresses the sequential increment only
- redirect  in  1  jump/branch taken; load redirect_target
- redirect_target  in  XLEN  jump/branch destination
- call  in  1  qualifies redirect; push the return address
- ret  in  1  return; pop the RAS into PC
- trap  in  1  exception entry
- pc  out  XLEN  current PC, registered
- pc_next  out  XLEN  combinational value PC takes at the next edge
- epc  out  XLEN  PC captured at the last trap or underflow, registered
- ras_empty  out  1  RAS holds 0 entries
- ras_full  out  1  RAS holds RAS_DEPTH entries
- ras_underflow  out  1  registered one-cycle pulse; ret issued with RAS empty

## Operation

- Next-PC priority, highest first, evaluated each cycle:
  1. trap: pc ← TRAP_VEC, epc ← pc. RAS untouched. call and ret are ignored.
  2. redirect: pc ← redirect_target. If call is also high, push pc+INC. A ret in the same cycle is ignored and no pop occurs.
  3. ret with RAS non-empty: pc ← top of stack; pop.
  4. ret with RAS empty: pc ← TRAP_VEC, epc ← pc, ras_underflow pulses.
  5. stall: pc holds.
  6. Otherwise pc ← pc+INC.
- Control transfers (1–4) take effect even when stall is high.
- call without redirect is ignored.
- Arithmetic: pc+INC is modulo 2^XLEN; all-ones+1 wraps to 0 with no flag.
- RAS is circular, with a top pointer and a count in 0..RAS_DEPTH:
  - Push when full overwrites the oldest entry. Count stays at RAS_DEPTH and ras_full stays high.
  - Pop returns the most recent push.
- pc_next equals the value pc takes on the next edge; it is combinational from the inputs and the state.
- Reset values: pc = RESET_VEC, epc = 0, RAS count = 0, ras_empty = 1, ras_full = 0, ras_underflow = 0. RAS entry contents are don't-care.

## Timing

- Every update is registered and takes one cycle from the input edge to the new pc.
- The return address pushed on call is the pc of the call cycle plus INC.
- ras_empty and ras_full reflect the count after the edge.
- ras_underflow is high for exactly the one cycle after the offending ret edge.
- Reset asserted mid-sequence forces all reset values immediately (asynchronously). Inputs sampled during reset are ignored, and the first update happens at the first rising edge after reset deasserts.

## Structure

- Shared package pc_pkg holds:
  - the default XLEN constant;
  - an enum pc_sel_e {SEL_TRAP, SEL_REDIR, SEL_RET, SEL_UNDER, SEL_HOLD, SEL_INC}, the priority encoder output shared with trace and debug logic.
- Sub-module pc_ras:
  - parameters XLEN and RAS_DEPTH;
  - ports push, push_data, pop, top, empty, full;
  - contains the circular storage, the top pointer and the count.
- The top level holds the priority mux, pc, epc and underflow registers.

## Test plan

- Reset then 3 free-running cycles → pc = RESET_VEC, then 1, 2, 3. With XLEN=4, INC=1 starting from 15 → next pc = 0.
- stall high for 2 cycles at pc=5, with redirect to 0x40 on the second cycle → pc 5, then 0x40, then 0x41 after stall drops.
- At pc=8, call+redirect to 0x100; run 2 cycles, then ret → pc 0x100, 0x101, 0x102, then 9. RAS empty afterwards.
- RAS_DEPTH=4: push 5 calls from pcs 10, 20, 30, 40, 50, then 5 rets → returns 51, 41, 31, 21, then underflow. On underflow pc = TRAP_VEC, epc = pc at the ret, and ras_underflow is a one-cycle pulse.
- trap, redirect, ret and call asserted in the same cycle at pc=0x33 → pc = TRAP_VEC, epc = 0x33, RAS count unchanged.
- reset asserted asynchronously mid-cycle after 2 pushes → pc = RESET_VEC at once, ras_empty = 1, a following ret underflows.
